// File: rtl/lane_pkg.sv
// lane_pkg: shared defaults and FSM state type for the lane serializer.
//   LANE_W_DEF : width of one lane word
//   LANES_DEF  : lanes per input word
//   DEPTH_DEF  : input-word buffer entries (power of two, >= 2)
//   state_t    : serializer FSM states (IDLE = buffer empty, SEND = non-empty)
package lane_pkg;

  localparam int unsigned LANE_W_DEF = 12;
  localparam int unsigned LANES_DEF  = 3;
  localparam int unsigned DEPTH_DEF  = 2;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

endpackage

// File: rtl/lane_fifo.sv
// lane_fifo: word buffer feeding the lane serializer.
//   clk, rst_n : clock, asynchronous active-low reset (clears pointers)
//   push/wdata : write wdata at the tail (ignored when full)
//   pop/rdata  : rdata is the head word; pop advances the head (ignored when empty)
//   full/empty : registered occupancy flags
//   count      : registered occupancy (0..DEPTH)
module lane_fifo
  import lane_pkg::*;
#(
  parameter int unsigned WIDTH = LANE_W_DEF * LANES_DEF,
  parameter int unsigned DEPTH = DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign count   = wr_ptr - rd_ptr;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage is not reset: contents are only observed through valid pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/lane_serializer.sv
// lane_serializer: buffers LANES*LANE_W-bit words and emits them one lane per
// beat, lane 0 first, over a valid/ready output.
//   clk, rst_n         : clock, asynchronous active-low reset
//   in_data/in_valid   : input word and its valid
//   in_ready           : buffer has room (registered occupancy only)
//   out_data/out_valid : current lane beat and its valid (zero when not valid)
//   out_ready          : downstream accepts the beat
//   out_last           : beat is lane LANES-1 of its word
//   out_parity         : XOR reduction of out_data
//   beat_cnt           : wrapping count of completed output beats
module lane_serializer
  import lane_pkg::*;
#(
  parameter int unsigned LANE_W = LANE_W_DEF,
  parameter int unsigned LANES  = LANES_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [LANES*LANE_W-1:0]   in_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [LANE_W-1:0]         out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      out_last,
  output logic                      out_parity,
  output logic [15:0]               beat_cnt
);

  localparam int unsigned IDX_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  state_t                    state;
  state_t                    state_next;
  logic [IDX_W-1:0]          idx;
  logic                      init_done;
  logic [LANES*LANE_W-1:0]   head;
  logic                      full;
  logic                      empty;
  logic [CNT_W-1:0]          count;
  logic                      push;
  logic                      pop;
  logic                      beat;
  logic                      is_last;
  logic [LANE_W-1:0]         lane_sel;

  // init_done holds in_ready low through reset and for the release cycle.
  assign in_ready  = init_done && !full;
  assign push      = in_valid && in_ready;
  assign out_valid = (state == SEND);
  assign is_last   = (idx == IDX_W'(LANES - 1));
  assign beat      = out_valid && out_ready;
  assign pop       = beat && is_last;

  lane_fifo #(
    .WIDTH (LANES * LANE_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (in_data),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (push) state_next = SEND;
      SEND: if ((pop && !push && count == CNT_W'(1)) || empty) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    lane_sel = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      if (idx == IDX_W'(k)) lane_sel = head[k*LANE_W +: LANE_W];
    end
  end

  assign out_data   = out_valid ? lane_sel : '0;
  assign out_last   = out_valid && is_last;
  assign out_parity = ^out_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      init_done <= 1'b0;
      beat_cnt  <= '0;
    end else begin
      state     <= state_next;
      init_done <= 1'b1;
      if (beat) begin
        idx      <= is_last ? '0 : idx + 1'b1;
        beat_cnt <= beat_cnt + 16'd1;
      end
    end
  end

endmodule
